// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// Retires two multiplier bits per clock behind a start/busy/done handshake.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N    = WIDTH + 2;
  localparam int AW   = WIDTH + 4;
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [AW-1:0]   a;
  logic [AW-1:0]   m;
  logic [N-1:0]    q;
  logic            qm1;
  logic [CW-1:0]   cnt;

  logic [2:0]      sel;
  logic [AW-1:0]   m2;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic signed [AW+N:0] sh;

  // Booth recode of the current digit and one add/shift step
  always_comb begin
    sel    = {q[1:0], qm1};
    m2     = {m[AW-2:0], 1'b0};
    addend = '0;
    unique case (1'b1)
      (sel == 3'b001) || (sel == 3'b010): addend = m;
      (sel == 3'b011):                    addend = m2;
      (sel == 3'b100):                    addend = -m2;
      (sel == 3'b101) || (sel == 3'b110): addend = -m;
      default:                            addend = '0;
    endcase
    sum = a + addend;
    sh  = $signed({sum, q, qm1}) >>> 2;
  end

  // Controller and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            m <= {{(AW-WIDTH){multiplicand[WIDTH-1] & signed_mode}},
                  multiplicand};
            q <= {{(N-WIDTH){multiplier[WIDTH-1] & signed_mode}},
                  multiplier};
            qm1   <= 1'b0;
            a     <= '0;
            cnt   <= CW'(ITER);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a   <= sh[AW+N:N+1];
          q   <= sh[N:1];
          qm1 <= sh[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product <= sh[2*WIDTH:1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
